pmp_csr_regs: RTL
=================

Name: pmp_csr_regs

Overview:
- Upstream configuration stage for the combinational PMP checker.
- Holds the 16 pmpcfg entries and 16 pmpaddr registers, and services CSR reads and writes from the CSR file.
- Enforces RISC-V lock, TOR-lock and WARL rules.
- Drives registered conf_o / conf_addr_o straight into the PMP checkers, and pulses flush_o so fetch/TLB state is discarded after any PMP reconfiguration.

Parameters:
- XLEN, 64, CSR data width; 32 or 64 only.
- PMP_LEN, 54, stored pmpaddr width (rv32: 32).
- NR_ENTRIES, 8, implemented entries, 0..16; entries >= NR_ENTRIES are hardwired zero.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- csr_addr_i  in  12  CSR address
- csr_we_i  in  1  write strobe, one access per cycle
- csr_wdata_i  in  XLEN  write data
- csr_hit_o  out  1  csr_addr_i decodes to a PMP CSR (combinational)
- csr_illegal_o  out  1  hit but address illegal for this XLEN (combinational)
- csr_rdata_o  out  XLEN  read data for csr_addr_i (combinational, current register state)
- conf_o  out  16 x riscv::pmpcfg_t  entry configs to the PMP checkers
- conf_addr_o  out  16 x PMP_LEN  entry addresses to the PMP checkers
- flush_o  out  1  one-cycle pulse after a legal PMP write

Behaviour:
- Decoded address ranges:
  - pmpcfg: 0x3A0-0x3A3.
  - pmpaddr: 0x3B0-0x3BF.
  - Any other address: hit=0, illegal=0, rdata=0, writes have no effect.
- XLEN=64:
  - 0x3A1 and 0x3A3 give hit=1, illegal=1, rdata=0; writes are ignored.
  - 0x3A0 maps entries 0-7 and 0x3A2 maps entries 8-15, byte k = entry base+k.
- XLEN=32: 0x3An maps entries 4n..4n+3.
- pmpcfg byte layout: [7] L, [6:5] reserved, [4:3] A (OFF/TOR/NA4/NAPOT), [2] X, [1] W, [0] R.
- Writes commit on the rising edge where csr_we_i=1. Outputs reflect the new value from the next cycle; write-to-visible latency is 1 cycle.
- pmpcfg write, evaluated per byte against pre-write state:
  - Locked entry (L=1): byte ignored.
  - Byte with W=1 and R=0 (reserved encoding): entire byte ignored, old value kept.
  - Otherwise: store with reserved bits forced to 0.
  - Entry index >= NR_ENTRIES: ignored, reads 0.
- pmpaddr[i] write:
  - Ignored if cfg[i].L=1.
  - Ignored if i<15 and cfg[i+1].L=1 with cfg[i+1].A=TOR, using pre-write cfg.
  - Otherwise stores csr_wdata_i[PMP_LEN-1:0].
  - Reads return the value zero-extended to XLEN.
- Locks are sticky until reset; no write can clear L.
- Same-cycle lock interaction: a cfg write setting L only affects writes from the following cycle. Only one CSR access per cycle is possible.
- flush_o:
  - Asserted exactly one cycle after any write with hit=1 and illegal=0, even if every byte was lock-ignored.
  - Back-to-back writes give back-to-back pulses.
- Reset (rst_ni=0, asynchronous):
  - All cfg bytes = 0 (OFF, unlocked, no permissions), all pmpaddr = 0, flush_o=0.
  - Reset asserted mid-write discards the write.
- Outputs conf_o / conf_addr_o are direct register outputs with no combinational path from csr inputs.
- csr_rdata_o reflects register state before any same-cycle write (read-old).

Test Plan:
- Reset, then read 0x3A0 and 0x3B0..0x3BF -> all 0, flush_o=0, conf_o all OFF.
- XLEN=64: write 0x3A0=0x0000_0000_0000_1F0F, then read -> 0x...1F0F; conf_o[0]=0x0F, conf_o[1]=0x1F; flush_o high exactly 1 cycle after the write.
- Write cfg byte 0 = 0x02 (W=1, R=0) -> byte 0 unchanged (0x0F kept), other bytes of the same write applied.
- Set cfg[1]=0x88 (L=1, TOR), then write 0x3B0=0x1234 and 0x3B1=0x5678 -> both ignored (pmpaddr0 via TOR-lock, pmpaddr1 via own lock); writing 0x3A0 byte 1=0x00 -> still 0x88.
- XLEN=64: access 0x3A1 -> hit=1, illegal=1, rdata=0, no flush; access 0x3C0 -> hit=0; NR_ENTRIES=8: write 0x3A2=all-ones -> reads 0.
- Assert rst_ni low asynchronously mid-sequence after locks are set -> all cfg/addr cleared immediately; subsequent writes accepted.

Source files
------------

// File: rtl/riscv.sv
// riscv: shared RISC-V privileged-architecture types used by the PMP path.
//   pmp_addr_mode_t : pmpcfg A field encoding (OFF / TOR / NA4 / NAPOT)
//   pmpcfg_t        : one pmpcfg byte, {L, reserved[1:0], A[1:0], X, W, R}
package riscv;

   typedef enum logic [1:0] {
      OFF   = 2'b00,
      TOR   = 2'b01,
      NA4   = 2'b10,
      NAPOT = 2'b11
   } pmp_addr_mode_t;

   typedef struct packed {
      logic           locked;
      logic [1:0]     reserved;
      pmp_addr_mode_t addr_mode;
      logic           x;
      logic           w;
      logic           r;
   } pmpcfg_t;

endpackage

// File: rtl/pmp_csr_regs.sv
// pmp_csr_regs: PMP configuration register bank that sits in front of the
// combinational PMP checkers. It holds 16 pmpcfg bytes and 16 pmpaddr
// registers, services CSR reads and writes, and applies the lock, TOR-lock
// and WARL rules.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   csr_addr_i      CSR address (one access per cycle)
//   csr_we_i        write strobe
//   csr_wdata_i     write data, XLEN bits
//   csr_hit_o       address is a PMP CSR (combinational)
//   csr_illegal_o   PMP CSR that does not exist for this XLEN (combinational)
//   csr_rdata_o     read data, register state before any same-cycle write
//   conf_o          16 entry configs, straight from flops
//   conf_addr_o     16 entry addresses, straight from flops
//   flush_o         one-cycle pulse after every legal PMP write
module pmp_csr_regs #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned PMP_LEN    = 54,
   parameter int unsigned NR_ENTRIES = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [11:0]                  csr_addr_i,
   input  logic                         csr_we_i,
   input  logic [XLEN-1:0]              csr_wdata_i,
   output logic                         csr_hit_o,
   output logic                         csr_illegal_o,
   output logic [XLEN-1:0]              csr_rdata_o,
   output riscv::pmpcfg_t [15:0]        conf_o,
   output logic [15:0][PMP_LEN-1:0]     conf_addr_o,
   output logic                         flush_o
);

   // Bytes per pmpcfg CSR: 8 on rv64, 4 on rv32.
   localparam int unsigned NB = XLEN / 8;
   // Bit i set when entry i is implemented; other entries never accept writes.
   localparam logic [15:0] IMPL_MASK = 16'((17'd1 << NR_ENTRIES) - 17'd1);
   // Reserved bits [6:5] read back as zero.
   localparam logic [7:0] CFG_WARL_MASK = 8'h9F;

   riscv::pmpcfg_t [15:0]        cfg_q, cfg_d;
   logic [15:0][PMP_LEN-1:0]     addr_q, addr_d;
   logic                         flush_q;

   logic       is_cfg;
   logic       is_addr;
   logic       legal_write;
   logic [3:0] cfg_base;
   logic [3:0] addr_idx;
   logic [3:0] next_idx;
   logic       tor_locked;
   logic       addr_wr_ok;

   // ---------------------------------------------------------------- decode
   assign is_cfg        = (csr_addr_i[11:4] == 8'h3A) && (csr_addr_i[3:2] == 2'b00);
   assign is_addr       = (csr_addr_i[11:4] == 8'h3B);
   assign csr_hit_o     = is_cfg | is_addr;
   // rv64 packs eight entries per CSR, so the odd pmpcfg addresses do not exist.
   assign csr_illegal_o = is_cfg && (XLEN == 64) && csr_addr_i[0];
   assign legal_write   = csr_we_i && csr_hit_o && !csr_illegal_o;

   // First entry covered by the addressed pmpcfg CSR: 4n on rv32, and on rv64
   // the same formula gives 0 / 8 for the two legal addresses.
   assign cfg_base = {csr_addr_i[1:0], 2'b00};
   assign addr_idx = csr_addr_i[3:0];
   assign next_idx = addr_idx + 4'd1;

   // pmpaddr[i] is frozen when entry i+1 is a locked TOR region, because
   // pmpaddr[i] is that region's lower bound. Entry 15 has no successor.
   assign tor_locked = (addr_idx != 4'hF) && cfg_q[next_idx].locked &&
                       (cfg_q[next_idx].addr_mode == riscv::TOR);
   assign addr_wr_ok = IMPL_MASK[addr_idx] && !cfg_q[addr_idx].locked && !tor_locked;

   // ------------------------------------------------------------------ read
   always_comb begin
      // NOTE: every signal written in always_comb gets a default first so
      // no path leaves it unassigned and no latch is inferred.
      csr_rdata_o = '0;
      if (is_cfg && !csr_illegal_o) begin
         for (int i = 0; i < NB; i++) begin
            csr_rdata_o[8*i +: 8] = cfg_q[cfg_base + 4'(i)];
         end
      end else if (is_addr) begin
         csr_rdata_o = XLEN'(addr_q[addr_idx]);
      end
   end

   // ------------------------------------------------------------ next state
   // All legality checks look at cfg_q, so a lock set by this write only
   // takes effect from the next access.
   always_comb begin
      cfg_d  = cfg_q;
      addr_d = addr_q;
      if (csr_we_i && is_cfg && !csr_illegal_o) begin
         for (int i = 0; i < NB; i++) begin
            // W=1 with R=0 is a reserved encoding: keep the whole old byte.
            if (IMPL_MASK[cfg_base + 4'(i)] && !cfg_q[cfg_base + 4'(i)].locked &&
                !(csr_wdata_i[8*i + 1] && !csr_wdata_i[8*i])) begin
               cfg_d[cfg_base + 4'(i)] = riscv::pmpcfg_t'(csr_wdata_i[8*i +: 8] & CFG_WARL_MASK);
            end
         end
      end
      if (csr_we_i && is_addr && addr_wr_ok) begin
         addr_d[addr_idx] = csr_wdata_i[PMP_LEN-1:0];
      end
   end

   // ------------------------------------------------------------- registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: the whole register bank is reset, not just control state:
         // software relies on every entry coming up OFF and unlocked, and
         // reset is the only way to clear a lock.
         cfg_q   <= '0;
         addr_q  <= '0;
         flush_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments for all state so every flop
         // samples the pre-edge values regardless of statement order.
         cfg_q   <= cfg_d;
         addr_q  <= addr_d;
         // Pulses even when every byte was lock-ignored: software asked for
         // a reconfiguration, so downstream caches are dropped anyway.
         flush_q <= legal_write;
      end
   end

   assign conf_o      = cfg_q;
   assign conf_addr_o = addr_q;
   assign flush_o     = flush_q;

endmodule
